// File: rtl/mover_2d_src_reader.sv
// mover_2d_src_reader: read-side fetch engine for the 2D mover.
// Walks a 2D source region (base, items per row, rows, row stride), issues AXI4 INCR read
// bursts, and streams the returned items in order through a valid/ready output.
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   go, cfg_*              start pulse and region description (sampled on go)
//   busy, done, error      status: transfer active, completion pulse, sticky error
//   M_AXI_SRC_AR*/R*       AXI4 read address / read data channels
//   out_*                  item stream with end-of-row and end-of-transfer tags
module mover_2d_src_reader #(
    parameter int unsigned M_AXI_WIDTH_ID = 4,
    parameter int unsigned M_AXI_WIDTH_AD = 32,
    parameter int unsigned M_AXI_WIDTH_DA = 32,
    parameter int unsigned M_AXI_WIDTH_DS = M_AXI_WIDTH_DA / 8,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      go,
    input  logic [M_AXI_WIDTH_AD-1:0] cfg_addr,
    input  logic [15:0]               cfg_width,
    input  logic [15:0]               cfg_height,
    input  logic [M_AXI_WIDTH_AD-1:0] cfg_stride,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [M_AXI_WIDTH_ID-1:0] M_AXI_SRC_ARID,
    output logic [M_AXI_WIDTH_AD-1:0] M_AXI_SRC_ARADDR,
    output logic [7:0]                M_AXI_SRC_ARLEN,
    output logic [2:0]                M_AXI_SRC_ARSIZE,
    output logic [1:0]                M_AXI_SRC_ARBURST,
    output logic                      M_AXI_SRC_ARVALID,
    input  logic                      M_AXI_SRC_ARREADY,
    input  logic [M_AXI_WIDTH_ID-1:0] M_AXI_SRC_RID,
    input  logic [M_AXI_WIDTH_DA-1:0] M_AXI_SRC_RDATA,
    input  logic [1:0]                M_AXI_SRC_RRESP,
    input  logic                      M_AXI_SRC_RLAST,
    input  logic                      M_AXI_SRC_RVALID,
    output logic                      M_AXI_SRC_RREADY,
    output logic [M_AXI_WIDTH_DA-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last_row,
    output logic                      out_last
);

    localparam int unsigned LOG_DS = $clog2(M_AXI_WIDTH_DS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FIFO_W = M_AXI_WIDTH_DA + 2;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    state_e                    state_q, state_d;
    logic [M_AXI_WIDTH_AD-1:0] cur_addr_q, cur_addr_d, row_base_q, row_base_d;
    logic [M_AXI_WIDTH_AD-1:0] stride_q, stride_d;
    logic [15:0]               width_q, width_d, items_left_q, items_left_d;
    logic [15:0]               rows_left_q, rows_left_d, beat_cnt_q, beat_cnt_d;
    logic                      error_q, error_d, done_q, done_d, fin_q, fin_d;

    logic [FIFO_W-1:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic [FIFO_W-1:0]         rd_word;
    logic                      push, pop, tag_last_row, tag_last;

    logic [12:0]               page_bytes;
    logic [15:0]               page_beats, beats, free_slots;
    logic                      go_ok, burst_end, row_end, final_row;
    logic                      unused_rid;

    assign unused_rid = ^M_AXI_SRC_RID;

    // Burst size: limited by what is left of the row, the burst cap and the 4 KB page.
    always_comb begin
        page_bytes = 13'd4096 - {1'b0, cur_addr_q[11:0]};
        page_beats = 16'(page_bytes >> LOG_DS);
        beats      = items_left_q;
        if (beats > 16'(MAX_BURST)) beats = 16'(MAX_BURST);
        if (beats > page_beats)     beats = page_beats;
    end

    // Space is reserved from the registered count; pops only grow it while waiting.
    assign free_slots = 16'(FIFO_DEPTH) - 16'(count_q);
    assign burst_end  = (beat_cnt_q == beats - 16'd1);
    assign row_end    = (items_left_q == beats);
    assign final_row  = (rows_left_q == 16'd1);

    // fin_q keeps busy high through the done cycle so a go there is ignored.
    assign busy  = (state_q != StIdle) || fin_q;
    assign done  = done_q;
    assign error = error_q;
    assign go_ok = go && !busy;

    assign M_AXI_SRC_ARID    = '0;
    assign M_AXI_SRC_ARSIZE  = 3'(LOG_DS);
    assign M_AXI_SRC_ARBURST = 2'b01;
    assign M_AXI_SRC_ARADDR  = cur_addr_q;
    assign M_AXI_SRC_ARVALID = (state_q == StAddr) && (free_slots >= beats);
    assign M_AXI_SRC_ARLEN   = (state_q == StAddr) ? 8'(beats - 16'd1) : 8'd0;
    assign M_AXI_SRC_RREADY  = (state_q == StData);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        row_base_d   = row_base_q;
        stride_d     = stride_q;
        width_d      = width_q;
        items_left_d = items_left_q;
        rows_left_d  = rows_left_q;
        beat_cnt_d   = beat_cnt_q;
        error_d      = error_q;
        done_d       = 1'b0;
        fin_d        = 1'b0;
        push         = 1'b0;
        tag_last_row = 1'b0;
        tag_last     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go_ok) begin
                    error_d      = 1'b0;
                    cur_addr_d   = cfg_addr;
                    row_base_d   = cfg_addr;
                    stride_d     = cfg_stride;
                    width_d      = cfg_width;
                    items_left_d = cfg_width;
                    rows_left_d  = cfg_height;
                    beat_cnt_d   = 16'd0;
                    if (cfg_width == 16'd0 || cfg_height == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (M_AXI_SRC_ARVALID && M_AXI_SRC_ARREADY) begin
                    state_d    = StData;
                    beat_cnt_d = 16'd0;
                end
            end
            StData: begin
                if (M_AXI_SRC_RVALID) begin
                    push         = 1'b1;
                    tag_last_row = burst_end && row_end;
                    tag_last     = tag_last_row && final_row;
                    if (M_AXI_SRC_RRESP != 2'b00)      error_d = 1'b1;
                    // RLAST is only checked; the beat count alone drives progress.
                    if (M_AXI_SRC_RLAST != burst_end) error_d = 1'b1;
                    if (burst_end) begin
                        beat_cnt_d = 16'd0;
                        if (row_end && final_row) begin
                            state_d = StDrain;
                        end else if (row_end) begin
                            row_base_d   = row_base_q + stride_q;
                            cur_addr_d   = row_base_q + stride_q;
                            items_left_d = width_q;
                            rows_left_d  = rows_left_q - 16'd1;
                            state_d      = StAddr;
                        end else begin
                            cur_addr_d   = cur_addr_q + (M_AXI_WIDTH_AD'(beats) << LOG_DS);
                            items_left_d = items_left_q - beats;
                            state_d      = StAddr;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 16'd1;
                    end
                end
            end
            StDrain: begin
                if (pop && rd_word[FIFO_W-1]) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            row_base_q   <= '0;
            stride_q     <= '0;
            width_q      <= '0;
            items_left_q <= '0;
            rows_left_q  <= '0;
            beat_cnt_q   <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            fin_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            row_base_q   <= row_base_d;
            stride_q     <= stride_d;
            width_q      <= width_d;
            items_left_q <= items_left_d;
            rows_left_q  <= rows_left_d;
            beat_cnt_q   <= beat_cnt_d;
            error_q      <= error_d;
            done_q       <= done_d;
            fin_q        <= fin_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= {tag_last, tag_last_row, M_AXI_SRC_RDATA};
    end

    assign rd_word      = mem_q[rd_ptr_q];
    assign out_valid    = (count_q != '0);
    assign pop          = out_valid && out_ready;
    assign out_data     = out_valid ? rd_word[M_AXI_WIDTH_DA-1:0] : '0;
    assign out_last_row = out_valid && rd_word[FIFO_W-2];
    assign out_last     = out_valid && rd_word[FIFO_W-1];

endmodule

// File: tb/tb_mover_2d_src_reader.sv
// Scoreboard bench for mover_2d_src_reader: a reference model expands each region into the
// expected AR bursts and item stream; a randomized AXI slave and an output monitor compare.
module tb_mover_2d_src_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go;
    logic [31:0] cfg_addr, cfg_stride;
    logic [15:0] cfg_width, cfg_height;
    logic        busy, done, error;
    logic [3:0]  ARID, RID;
    logic [31:0] ARADDR, RDATA, out_data;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST, RRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        out_valid, out_ready, out_last_row, out_last;

    always #5 clk = ~clk;

    mover_2d_src_reader dut (
        .ACLK(clk), .ARESETn(rst_n), .go(go), .cfg_addr(cfg_addr), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_stride(cfg_stride), .busy(busy), .done(done),
        .error(error), .M_AXI_SRC_ARID(ARID), .M_AXI_SRC_ARADDR(ARADDR),
        .M_AXI_SRC_ARLEN(ARLEN), .M_AXI_SRC_ARSIZE(ARSIZE), .M_AXI_SRC_ARBURST(ARBURST),
        .M_AXI_SRC_ARVALID(ARVALID), .M_AXI_SRC_ARREADY(ARREADY), .M_AXI_SRC_RID(RID),
        .M_AXI_SRC_RDATA(RDATA), .M_AXI_SRC_RRESP(RRESP), .M_AXI_SRC_RLAST(RLAST),
        .M_AXI_SRC_RVALID(RVALID), .M_AXI_SRC_RREADY(RREADY), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last_row(out_last_row),
        .out_last(out_last)
    );

    typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
    typedef struct {logic [31:0] data; logic lr; logic l;} item_t;

    ar_t   exp_ar[$];
    ar_t   pend[$];
    item_t exp_items[$];
    int    n_cmp = 0, n_bad = 0;
    int    r_hs_cnt = 0, beat_total = 0, err_beat = -1, bad_rlast_beat = -1, done_cnt = 0;
    bit    hold_low = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Reference model: split every row into bursts capped by row end, 16 beats and 4 KB.
    task automatic build(input logic [31:0] addr, input int w, input int h,
                         input logic [31:0] stride);
        for (int r = 0; r < h; r++) begin
            logic [31:0] ra, a;
            int rem, b, pg;
            ra = addr + 32'(r) * stride;
            a = ra;
            rem = w;
            while (rem > 0) begin
                b = (rem > 16) ? 16 : rem;
                pg = (4096 - int'(a & 32'hFFF)) / 4;
                if (b > pg) b = pg;
                exp_ar.push_back(ar_t'{a, 8'(b - 1)});
                a = a + 32'(4 * b);
                rem -= b;
            end
            for (int i = 0; i < w; i++)
                exp_items.push_back(item_t'{fdat(ra + 32'(4 * i)), i == w - 1,
                                            (i == w - 1) && (r == h - 1)});
        end
    endtask

    // AXI slave: handshakes are evaluated at negedge, drives change #1 after posedge.
    initial begin
        ar_t e_rec, a_rec;
        int r_idx;
        bit consumed;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 0; r_idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete(); r_idx = 0; RVALID = 0; RLAST = 0; RRESP = 0; ARREADY = 0;
                continue;
            end
            consumed = 0;
            if (ARVALID && ARREADY) begin
                a_rec.addr = ARADDR;
                a_rec.len = ARLEN;
                if (exp_ar.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ar_unexpected: got addr %0h len %0d, expected none",
                             ARADDR, ARLEN);
                end else begin
                    e_rec = exp_ar.pop_front();
                    chk("ar_addr", ARADDR, e_rec.addr);
                    chk("ar_len", ARLEN, e_rec.len);
                    chk("ar_fixed", {ARID, ARSIZE, ARBURST}, {4'd0, 3'd2, 2'd1});
                end
                pend.push_back(a_rec);
            end
            if (RVALID && RREADY) begin
                consumed = 1;
                r_hs_cnt++; beat_total++; r_idx++;
                if (r_idx > int'(pend[0].len)) begin
                    void'(pend.pop_front());
                    r_idx = 0;
                end
            end
            @(posedge clk);
            #1;
            ARREADY = ($urandom_range(0, 3) != 0);
            if (!(RVALID && !consumed))
                RVALID = (pend.size() != 0) && ($urandom_range(0, 2) != 0);
            if (pend.size() != 0) begin
                RDATA = fdat(pend[0].addr + 32'(4 * r_idx));
                RLAST = (r_idx == int'(pend[0].len)) ^ (beat_total == bad_rlast_beat);
                RRESP = (beat_total == err_beat) ? 2'b10 : 2'b00;
            end
        end
    end

    // Output monitor: pops the scoreboard on every out handshake.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_items.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL out_unexpected: got %0h, expected no item", out_data);
                    end else begin
                        e = exp_items.pop_front();
                        chk("out_item", {out_last, out_last_row, out_data}, {e.l, e.lr, e.data});
                    end
                end
            end
        end
    end

    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic start(input logic [31:0] addr, input int w, input int h,
                         input logic [31:0] stride);
        @(posedge clk);
        #1;
        go = 1; cfg_addr = addr; cfg_width = 16'(w); cfg_height = 16'(h); cfg_stride = stride;
        @(posedge clk);
        #1;
        go = 0;
    endtask

    task automatic wait_done(input bit exp_err, input int d0);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", n < 5000, 1);
        chk("busy_in_done", busy, 1);
        chk("error", error, exp_err);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_end", busy, 0);
        chk("done_count", done_cnt - d0, 1);
        chk("items_left", exp_items.size(), 0);
        chk("ars_left", exp_ar.size(), 0);
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int w, input int h,
                            input logic [31:0] stride, input int eb, input int rb,
                            input bit exp_err);
        int d0;
        err_beat = eb; bad_rlast_beat = rb; beat_total = 0;
        build(addr, w, h, stride);
        d0 = done_cnt;
        start(addr, w, h, stride);
        @(negedge clk);
        chk("busy_after_go", busy, 1);
        chk("error_cleared", error, 0);
        wait_done(exp_err, d0);
    endtask

    task automatic check_reset_outs();
        chk("rst_ar", {ARVALID, ARADDR, ARLEN, RREADY}, 42'd0);
        chk("rst_out", {out_valid, out_data, out_last, out_last_row, busy, done, error}, 38'd0);
    endtask

    task automatic zero_go(input int w, input int h);
        start(32'h6000, w, h, 32'd4);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_arvalid", ARVALID, 0);
        @(negedge clk);
        chk("zero_done_pulse", done, 0);
        chk("zero_arvalid2", ARVALID, 0);
    endtask

    initial begin
        int n, w, h;
        go = 0; cfg_addr = 0; cfg_width = 0; cfg_height = 0; cfg_stride = 0;
        repeat (3) @(negedge clk);
        check_reset_outs();
        @(posedge clk);
        #2;
        rst_n = 1;

        run_xfer(32'h1000, 4, 2, 32'h40, -1, -1, 0);
        run_xfer(32'h2000, 40, 1, 32'h0, -1, -1, 0);
        run_xfer(32'h0FF8, 8, 1, 32'h0, -1, -1, 0);

        // Output stalled: exactly one burst's worth may be buffered.
        hold_low = 1;
        err_beat = -1; bad_rlast_beat = -1; beat_total = 0;
        build(32'h3000, 64, 1, 32'h0);
        n = done_cnt;
        r_hs_cnt = 0;
        start(32'h3000, 64, 1, 32'h0);
        repeat (200) @(negedge clk);
        chk("buffered_items", r_hs_cnt, 16);
        chk("out_valid_held", out_valid, 1);
        chk("no_ar_when_full", ARVALID, 0);
        hold_low = 0;
        wait_done(0, n);

        run_xfer(32'h4000, 8, 1, 32'h20, 2, -1, 1);
        run_xfer(32'h4100, 8, 1, 32'h20, -1, 7, 1);
        run_xfer(32'h4200, 5, 3, 32'h100, -1, -1, 0);

        for (int k = 0; k < 6; k++) begin
            w = $urandom_range(1, 40);
            h = $urandom_range(1, 4);
            run_xfer(32'h8000 + 32'($urandom_range(0, 1023) << 2), w, h,
                     32'(w * 4) + 32'($urandom_range(0, 256) << 2),
                     (k == 3) ? int'($urandom_range(0, w * h - 1)) : -1, -1, k == 3);
        end

        zero_go(7, 0);
        zero_go(0, 3);

        // Reset in the middle of a data phase abandons the transfer.
        err_beat = -1; bad_rlast_beat = -1; beat_total = 0;
        build(32'h5000, 64, 2, 32'h400);
        start(32'h5000, 64, 2, 32'h400);
        n = 0;
        while (!RREADY && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_data", n < 1000, 1);
        @(posedge clk);
        #2;
        rst_n = 0;
        @(negedge clk);
        check_reset_outs();
        exp_ar.delete();
        exp_items.delete();
        @(posedge clk);
        #2;
        rst_n = 1;
        zero_go(4, 0);
        run_xfer(32'h7FF0, 12, 2, 32'h200, -1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mover_2d_src_reader.md
# mover_2d_src_reader

Read-side fetch engine for the 2D mover: walks a 2D source region (row base, items per row, rows, row stride), issues AXI4 INCR read bursts on the source master port, and delivers returned items, in order, to the mover datapath through a valid/ready stream. An internal credit-checked FIFO ensures every issued burst has space reserved, so RREADY never stalls mid-burst. It sits between the m_axi_src port and the mover's source FIFO / operation core.

## Interface
- M_AXI_WIDTH_ID, 4, AXI ID width
- M_AXI_WIDTH_AD, 32, AXI address width
- M_AXI_WIDTH_DA, 32, AXI data width; one item = one beat
- M_AXI_WIDTH_DS, M_AXI_WIDTH_DA/8, bytes per beat
- MAX_BURST, 16, max beats per burst (1..256)
- FIFO_DEPTH, 16, output FIFO depth (power of 2, ≥ MAX_BURST)

- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- go  in  1  start pulse; ignored while busy
- cfg_addr  in  AD  first-row byte address, DS-aligned; sampled on go
- cfg_width  in  16  items per row; sampled on go
- cfg_height  in  16  rows; sampled on go
- cfg_stride  in  AD  byte distance between row starts; sampled on go
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at completion
- error  out  1  sticky; cleared on next accepted go
- M_AXI_SRC_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ID/AD/8/3/2/1  AR channel
- M_AXI_SRC_ARREADY  in  1
- M_AXI_SRC_RID/RDATA/RRESP/RLAST/RVALID  in  ID/DA/2/1/1
- M_AXI_SRC_RREADY  out  1
- out_data  out  DA  item
- out_valid  out  1; out_ready  in  1
- out_last_row  out  1  item is last of its row
- out_last  out  1  item is final of transfer

## Operation
- ARID=0, ARSIZE=log2(DS), ARBURST=INCR(2'b01), constant.
- FSM: IDLE → (go, width≠0, height≠0) ADDR → DATA → ADDR (more bursts) or DRAIN (none left) → IDLE. go with width=0 or height=0: no AR; done next cycle, busy stays 0.
- Burst beats = min(row items remaining, MAX_BURST, (4096 − addr[11:0])/DS); ARLEN = beats−1. No burst crosses a row end or 4 KB boundary.
- ADDR: wait until FIFO free slots ≥ beats, then assert ARVALID; ARADDR/ARLEN held stable until ARREADY. One outstanding burst.
- DATA: RREADY=1; each RVALID beat pushed to FIFO with tags last_row/last computed from beat counters. Within row addr += beats·DS; at row end row_base += cfg_stride (modulo 2^AD).
- RRESP≠OKAY on any beat → error=1; data still pushed. RLAST absent on expected final beat or present early → error=1; engine advances on expected count, ignores RLAST for control.
- DRAIN: wait until final item (out_last) handshakes, then done pulse, busy=0, IDLE.
- busy=1 from cycle after accepted go until done cycle inclusive.

## Timing
- Reset values: ARVALID=0, ARADDR=0, ARLEN=0, RREADY=0, out_valid=0, out_data=0, out_last/out_last_row=0, busy=0, done=0, error=0; FIFO emptied, FSM IDLE. Reset mid-burst abandons transfer, outstanding R beats not consumed.
- go at edge N → ARVALID earliest at N+1.
- R beat accepted at edge M → out_valid at M+1 (FIFO write-to-read 1 cycle).
- FIFO push and pop same cycle allowed at any occupancy; free-slot check uses registered count.
- done asserted the cycle after final out handshake edge; go accepted the same cycle done is high is ignored (busy).

## Test plan
- addr=0x1000, width=4, height=2, stride=0x40 → ARs (0x1000,ARLEN 3),(0x1040,ARLEN 3); 8 items in order, out_last_row on 4th and 8th, out_last on 8th, one done pulse.
- width=40, height=1, addr=0x2000 → ARLEN 15 @0x2000, 15 @0x2040, 7 @0x2080; 40 items.
- addr=0x0FF8, width=8, height=1 → ARLEN 1 @0x0FF8, ARLEN 5 @0x1000; no 4 KB crossing.
- out_ready=0 for 200 cycles, width=64 → exactly 16 items buffered, no ARVALID after FIFO full until drain; all 64 items delivered, none lost or duplicated.
- RRESP=2'b10 on beat 3 of 8 → error=1, all 8 items delivered, done; next go clears error.
- ARESETn low during DATA → all outputs at reset values next cycle; go with height=0 → done 1 cycle later, no ARVALID.
